// File: rtl/pcihellocore_button_in.sv
// ============================================================================
// Module      : pcihellocore_button_in
// Description : Avalon-MM slave input port for the guitar fret/strum buttons.
//               Synchronizes the raw pins, optionally debounces them, latches
//               rising edges and raises a maskable level interrupt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: define BUTTON_IN_DEBOUNCE_EN to build one debounce counter per
//               input bit; left undefined, the synchronized level is used
//               directly and DEBOUNCE_CYCLES has no effect.
// Ports:
//   clk        in   1      system clock
//   reset_n    in   1      asynchronous, active-low reset
//   address    in   2      register select (0 DATA, 1 rsvd, 2 IRQMASK, 3 EDGECAP)
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data
//   readdata   out  32     read data, combinational, zero wait states
//   in_port    in   WIDTH  raw asynchronous button inputs
//   irq        out  1      level interrupt, active high
// ============================================================================
`default_nettype none

module pcihellocore_button_in #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] c_addr_data    = 2'd0;
  localparam logic [1:0] c_addr_irqmask = 2'd2;
  localparam logic [1:0] c_addr_edgecap = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_clr;
  logic             w_write;

  // Upper write-data bits are architecturally ignored.
  logic w_unused_wdata;
  assign w_unused_wdata = ^writedata;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous pins
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Stable level: debounced per bit, or the synchronized level directly
  // --------------------------------------------------------------------------
`ifdef BUTTON_IN_DEBOUNCE_EN
  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    // The counter only runs while the synchronized pin disagrees with the
    // accepted level; any bounce back to agreement restarts it from zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_sync2[gi] == r_level) begin
        r_cnt   <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync2[gi];
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end

    assign w_stable[gi] = r_level;
  end : g_debounce
`else
  assign w_stable = r_sync2;
`endif

  // --------------------------------------------------------------------------
  // Register writes, edge capture and interrupt
  // --------------------------------------------------------------------------
  assign w_write = chipselect & ~write_n;
  assign w_rise  = w_stable & ~r_stable_d;
  assign w_clr   = (w_write && (address == c_addr_edgecap)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= '0;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
    end else begin
      r_stable_d <= w_stable;
      if (w_write && (address == c_addr_irqmask)) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      // OR-ing the rise in after the clear makes a same-cycle set win.
      r_edgecap <= (r_edgecap & ~w_clr) | w_rise;
    end
  end

  // Built only from flop outputs, so no decode glitches reach the pin.
  assign irq = |(r_edgecap & r_irqmask);

  // --------------------------------------------------------------------------
  // Read mux (no side effects)
  // --------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      c_addr_data:    readdata[WIDTH-1:0] = w_stable;
      c_addr_irqmask: readdata[WIDTH-1:0] = r_irqmask;
      c_addr_edgecap: readdata[WIDTH-1:0] = r_edgecap;
      default:        readdata = '0;
    endcase
  end

endmodule : pcihellocore_button_in

`default_nettype wire

// File: tb/tb_pcihellocore_button_in.sv
// ============================================================================
// Module      : tb_pcihellocore_button_in
// Description : Directed self-checking bench for pcihellocore_button_in
//               (WIDTH=8, DEBOUNCE_CYCLES=4 when debounce is built in).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_pcihellocore_button_in;

`ifdef BUTTON_IN_DEBOUNCE_EN
  localparam int c_lat = 4;
`else
  localparam int c_lat = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;

  int checks;
  int errors;

  pcihellocore_button_in #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  // Write takes effect at the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;

    // ---- reset state ----
    tick(3);
    reset_n = 1'b1;
    tick(1);
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd1, 32'h0, "rst_rsvd");
    rd(2'd2, 32'h0, "rst_mask");
    rd(2'd3, 32'h0, "rst_edge");
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // ---- input latency and edge capture ----
    tick(1);
    in_port = 8'h05;                 // next edge is N
    tick(1 + c_lat);                 // after N(+lat)
    rd(2'd0, 32'h00, "lat_data_early");
    tick(1);                         // after N+1(+lat)
    rd(2'd0, 32'h05, "lat_data");
    rd(2'd3, 32'h00, "lat_edge_early");
    tick(1);                         // after N+2(+lat)
    rd(2'd3, 32'h05, "lat_edge");
    in_port = 8'h00;
    tick(4 + c_lat);
    rd(2'd0, 32'h00, "fall_data");
    rd(2'd3, 32'h05, "fall_not_captured");

    // ---- interrupt mask and W1C ----
    chk("irq_unmasked", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h04);
    chk("irq_mask04", {31'h0, irq}, 32'h1);
    rd(2'd2, 32'h04, "mask_rb");
    wr(2'd3, 32'h04);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    rd(2'd3, 32'h01, "edge_after_w1c");
    wr(2'd3, 32'h00);
    rd(2'd3, 32'h01, "edge_w0_noop");
    wr(2'd2, 32'h01);
    chk("irq_mask01", {31'h0, irq}, 32'h1);

    // ---- clear of bit0, then set-wins against a same-cycle clear ----
    wr(2'd3, 32'h01);
    rd(2'd3, 32'h00, "edge_cleared");
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    in_port = 8'h01;                 // next edge is N; rise lands at N+2(+lat)
    tick(1 + c_lat);
    tick(1);
    wr(2'd3, 32'h01);                // W1C at edge N+2(+lat)
    rd(2'd3, 32'h01, "set_wins");
    chk("irq_set_wins", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h01);
    rd(2'd3, 32'h00, "clear_after_set");
    in_port = 8'h00;
    tick(4 + c_lat);

    // ---- read-only / reserved writes, upper bits ----
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    in_port = 8'hA5;
    tick(3 + c_lat);
    rd(2'd0, 32'h0000_00A5, "data_tracks");
    rd(2'd1, 32'h0, "rsvd_zero");
    wr(2'd2, 32'hFFFF_FF3C);
    rd(2'd2, 32'h0000_003C, "mask_upper_zero");
    rd(2'd3, 32'h0000_00A5, "edge_upper_zero");

    // ---- edgecap=FF then asynchronous reset mid-run ----
    in_port = 8'h00;
    tick(4 + c_lat);
    wr(2'd3, 32'hFF);
    in_port = 8'hFF;
    tick(4 + c_lat);
    rd(2'd3, 32'hFF, "edge_all");
    chk("irq_all", {31'h0, irq}, 32'h1);
    #3;
    reset_n = 1'b0;                  // mid-cycle, away from any edge
    #1;
    chk("arst_irq", {31'h0, irq}, 32'h0);
    rd(2'd3, 32'h0, "arst_edge");
    rd(2'd2, 32'h0, "arst_mask");
    rd(2'd0, 32'h0, "arst_data");
    in_port = 8'h00;
    tick(2);
    reset_n = 1'b1;
    tick(4 + c_lat);

`ifdef BUTTON_IN_DEBOUNCE_EN
    // ---- debounce: short pulse rejected, long pulse accepted ----
    in_port = 8'h02;
    tick(3);
    in_port = 8'h00;
    tick(10);
    rd(2'd0, 32'h0, "db_short_data");
    rd(2'd3, 32'h0, "db_short_edge");
    in_port = 8'h02;                 // next edge is N; accepted at N+5
    tick(5);
    rd(2'd0, 32'h00, "db_long_early");
    tick(1);
    rd(2'd0, 32'h02, "db_long_data");
    tick(1);
    rd(2'd3, 32'h02, "db_long_edge");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule : tb_pcihellocore_button_in

`default_nettype wire
